shift_transmitter: RTL



---
 rtl/shift_transmitter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shift_transmitter.sv
// rtl/shift_transmitter.sv - parallel-to-serial transmitter feeding a downstream shift register's sr/ir or sl/il side.
// Optional trailing even-parity strobe is enabled by defining SHIFT_TRANSMITTER_PARITY_EN.
module shift_transmitter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  sr,
  output logic                  ir,
  output logic                  sl,
  output logic                  il,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
`ifdef SHIFT_TRANSMITTER_PARITY_EN
  localparam int NBITS = DATA_WIDTH + 1;
`else
  localparam int NBITS = DATA_WIDTH;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] shift_buf_q, shift_buf_n;
  logic                  dir_q, dir_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic                  sr_n, ir_n, sl_n, il_n, busy_n, done_n;
  logic                  next_bit;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
  logic                  par_q, par_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_buf_q <= '0;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      sr          <= 1'b0;
      ir          <= 1'b0;
      sl          <= 1'b0;
      il          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      shift_buf_q <= shift_buf_n;
      dir_q       <= dir_n;
      cnt_q       <= cnt_n;
      sr          <= sr_n;
      ir          <= ir_n;
      sl          <= sl_n;
      il          <= il_n;
      busy        <= busy_n;
      done        <= done_n;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
      par_q       <= par_n;
`endif
    end
  end

  // Outputs are computed one cycle ahead so each registered strobe lines up with its state.
  always_comb begin
    state_n     = state_q;
    shift_buf_n = shift_buf_q;
    dir_n       = dir_q;
    cnt_n       = cnt_q;
    sr_n        = 1'b0;
    ir_n        = 1'b0;
    sl_n        = 1'b0;
    il_n        = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    next_bit    = 1'b0;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
    par_n       = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n     = SHIFT;
          dir_n       = dir;
          cnt_n       = '0;
          shift_buf_n = dir ? (data << 1) : (data >> 1);
          sr_n        = ~dir;
          ir_n        = ~dir & data[0];
          sl_n        = dir;
          il_n        = dir & data[DATA_WIDTH-1];
          busy_n      = 1'b1;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
          par_n       = ^data;
`endif
        end
      end
      SHIFT: begin
        busy_n = 1'b1;
        cnt_n  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
`ifdef SHIFT_TRANSMITTER_PARITY_EN
          if (cnt_q == CW'(DATA_WIDTH - 1)) next_bit = par_q;
          else
`endif
          next_bit = dir_q ? shift_buf_q[DATA_WIDTH-1] : shift_buf_q[0];
          shift_buf_n = dir_q ? (shift_buf_q << 1) : (shift_buf_q >> 1);
          sr_n        = ~dir_q;
          ir_n        = ~dir_q & next_bit;
          sl_n        = dir_q;
          il_n        = dir_q & next_bit;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
